// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types and helpers for the RV64M multiply/divide unit.
//   u64 / u32      : plain data words
//   mdufunc_t      : operation select presented with each request
//   mdu_state_t    : control FSM states (IDLE, BUSY, DONE)
//   CNT_LOAD       : iteration counter preset (64 iterations, counting 63..0)
//   func_is_*      : decode helpers for mdufunc_t
//   word_fix       : low 32 bits sign-extended to 64 (W-suffix result format)
package mdu_pkg;

    typedef logic [63:0] u64;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        MDU_MUL   = 4'd0,
        MDU_DIV   = 4'd1,
        MDU_DIVU  = 4'd2,
        MDU_REM   = 4'd3,
        MDU_REMU  = 4'd4,
        MDU_MULW  = 4'd5,
        MDU_DIVW  = 4'd6,
        MDU_DIVUW = 4'd7,
        MDU_REMW  = 4'd8,
        MDU_REMUW = 4'd9
    } mdufunc_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_t;

    localparam logic [5:0] CNT_LOAD = 6'd63;

    function automatic logic func_is_word(input mdufunc_t f);
        case (f)
            MDU_MULW, MDU_DIVW, MDU_DIVUW, MDU_REMW, MDU_REMUW: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Signed divide/remainder; multiplies need no sign handling for the low half.
    function automatic logic func_is_signed(input mdufunc_t f);
        case (f)
            MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW: return 1'b1;
            default:                              return 1'b0;
        endcase
    endfunction

    function automatic logic func_is_mul(input mdufunc_t f);
        return (f == MDU_MUL) || (f == MDU_MULW);
    endfunction

    // Any divide-class operation (quotient or remainder).
    function automatic logic func_is_div(input mdufunc_t f);
        return !func_is_mul(f);
    endfunction

    function automatic logic func_is_rem(input mdufunc_t f);
        case (f)
            MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

    function automatic u64 word_fix(input logic word, input u64 v);
        return word ? {{32{v[31]}}, v[31:0]} : v;
    endfunction

endpackage

// File: rtl/mdu_divider.sv
// mdu_divider: restoring divider on unsigned magnitudes, one quotient bit per step.
//   clk, reset        : clock, synchronous active-high reset
//   start             : load dividend/divisor into the shift register
//   step              : perform one iteration this cycle
//   last              : this step is the final (64th) one
//   dividend, divisor : unsigned magnitudes, sampled on start
//   done              : final step happening this cycle (step & last)
//   quotient,
//   remainder         : result of the current step (value the register takes
//                       at the coming edge), so the caller can register the
//                       finished result on the same edge as the last step
import mdu_pkg::*;

module mdu_divider (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic step,
    input  logic last,
    input  u64   dividend,
    input  u64   divisor,
    output logic done,
    output u64   quotient,
    output u64   remainder
);

    logic [127:0] r_sr;       // {remainder, quotient}
    u64           r_divisor;

    logic [64:0]  w_hi;       // upper half after the shift, with carry-out bit
    logic         w_ge;
    u64           w_diff;
    logic [127:0] w_sr_next;

    always_comb begin
        // Shifted upper half can reach 2*divisor-1, so keep the bit shifted out.
        w_hi   = r_sr[127:63];
        w_ge   = (w_hi >= {1'b0, r_divisor});
        // Only consumed when w_ge, where the true difference fits in 64 bits.
        w_diff = w_hi[63:0] - r_divisor;
        if (w_ge) begin
            w_sr_next = {w_diff, r_sr[62:0], 1'b1};
        end else begin
            w_sr_next = {r_sr[126:0], 1'b0};
        end
        quotient  = w_sr_next[63:0];
        remainder = w_sr_next[127:64];
        done      = step & last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr      <= '0;
            r_divisor <= '0;
        end else if (start) begin
            r_sr      <= {64'd0, dividend};
            r_divisor <= divisor;
        end else if (step) begin
            r_sr      <= w_sr_next;
        end
    end

endmodule

// File: rtl/mdu.sv
// mdu: iterative RV64M multiply/divide unit with ready/valid request side.
//   clk, reset : clock, synchronous active-high reset
//   in_valid   : request offered; accepted on an edge with in_valid & in_ready
//   in_ready   : unit idle
//   a, b       : operands (rs1, rs2), sampled at accept
//   mdufunc    : operation select
//   flush      : abort anything in flight; blocks a same-cycle accept
//   out_valid  : one-cycle pulse, c is valid
//   c          : result, held until the next accept
// Build option: define MDU_FAST_MUL_EN to compute MUL/MULW in one step with
// the * operator (latency 1); otherwise multiplies use 64 shift-add
// iterations like the divider.
import mdu_pkg::*;

module mdu (
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  u64       a,
    input  u64       b,
    input  mdufunc_t mdufunc,
    input  logic     flush,
    output logic     out_valid,
    output u64       c
);

    mdu_state_t r_state;
    mdu_state_t w_state_next;
    logic [5:0] r_cnt;
    logic       r_out_valid;
    u64         r_c;
    logic       r_word;
    logic       r_is_div;
    logic       r_is_rem;
    logic       r_q_neg;
    logic       r_r_neg;
    u64         r_mcand;
    u64         r_mplier;
    u64         r_prod;

    logic       w_accept;
    logic       w_busy;
    logic       w_word;
    logic       w_signed;
    logic       w_rem;
    u64         w_a_ext;
    u64         w_b_ext;
    logic       w_a_neg;
    logic       w_b_neg;
    u64         w_a_mag;
    u64         w_b_mag;
    logic       w_div0;
    logic       w_ovf;
    logic       w_special;
    u64         w_special_raw;
    u64         w_special_res;
    logic       w_fast;
    u64         w_fast_res;
    u64         w_prod_next;
    logic       w_div_done;
    u64         w_quo;
    u64         w_rem_raw;
    u64         w_div_res;

    assign w_accept = in_valid && (r_state == ST_IDLE) && !flush;
    assign w_busy   = (r_state == ST_BUSY);

    // Request decode and operand conditioning (word ops extend the low half).
    always_comb begin
        w_word   = func_is_word(mdufunc);
        w_signed = func_is_signed(mdufunc);
        w_rem    = func_is_rem(mdufunc);
        if (w_word) begin
            w_a_ext = w_signed ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]};
            w_b_ext = w_signed ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]};
        end else begin
            w_a_ext = a;
            w_b_ext = b;
        end
        w_a_neg = w_signed && w_a_ext[63];
        w_b_neg = w_signed && w_b_ext[63];
        // -2^63 maps onto itself, which is the correct unsigned magnitude.
        w_a_mag = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
        w_b_mag = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;

        w_div0    = (w_b_ext == '0);
        w_ovf     = w_signed && (w_a_ext == 64'h8000_0000_0000_0000) && (w_b_ext == '1);
        w_special = func_is_div(mdufunc) && (w_div0 || w_ovf);
        if (w_div0) begin
            w_special_raw = w_rem ? w_a_ext : '1;
        end else begin
            w_special_raw = w_rem ? '0 : w_a_ext;
        end
        w_special_res = word_fix(w_word, w_special_raw);
    end

`ifdef MDU_FAST_MUL_EN
    assign w_fast     = func_is_mul(mdufunc);
    assign w_fast_res = word_fix(w_word, w_a_ext * w_b_ext);
`else
    assign w_fast     = 1'b0;
    assign w_fast_res = '0;
`endif

    // Shift-add multiplier: this cycle's partial product including bit0 of the multiplier.
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    mdu_divider u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (w_accept),
        .step      (w_busy && r_is_div),
        .last      (r_cnt == '0),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .done      (w_div_done),
        .quotient  (w_quo),
        .remainder (w_rem_raw)
    );

    // Restore signs: quotient negative when operand signs differ,
    // remainder follows the dividend.
    always_comb begin
        if (r_is_rem) begin
            w_div_res = r_r_neg ? (~w_rem_raw + 64'd1) : w_rem_raw;
        end else begin
            w_div_res = r_q_neg ? (~w_quo + 64'd1) : w_quo;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_special || w_fast) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        if (flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_c         <= '0;
            r_word      <= 1'b0;
            r_is_div    <= 1'b0;
            r_is_rem    <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
        end else begin
            r_state     <= w_state_next;
            r_out_valid <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_word   <= w_word;
                r_is_div <= func_is_div(mdufunc);
                r_is_rem <= w_rem;
                r_q_neg  <= w_a_neg ^ w_b_neg;
                r_r_neg  <= w_a_neg;
                r_cnt    <= CNT_LOAD;
                r_mcand  <= w_a_ext;
                r_mplier <= w_b_ext;
                r_prod   <= '0;
                if (w_special) begin
                    r_c <= w_special_res;
                end else if (w_fast) begin
                    r_c <= w_fast_res;
                end
            end else if (w_busy && !flush) begin
                r_cnt    <= r_cnt - 6'd1;
                r_prod   <= w_prod_next;
                r_mcand  <= {r_mcand[62:0], 1'b0};
                r_mplier <= {1'b0, r_mplier[63:1]};
                if (w_div_done) begin
                    r_c <= word_fix(r_word, w_div_res);
                end else if ((r_cnt == '0) && !r_is_div) begin
                    r_c <= word_fix(r_word, w_prod_next);
                end
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign c         = r_c;

endmodule

// File: tb/tb_mdu.sv
module tb_mdu;
    import mdu_pkg::*;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 65;
`endif
    localparam int DIV_LAT = 65;
    localparam int SPC_LAT = 1;

    logic     clk = 1'b0;
    logic     reset = 1'b1;
    logic     in_valid = 1'b0;
    logic     flush = 1'b0;
    logic     in_ready;
    logic     out_valid;
    u64       a = '0;
    u64       b = '0;
    u64       c;
    mdufunc_t mdufunc = MDU_MUL;

    always #5 clk = ~clk;

    mdu dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .mdufunc   (mdufunc),
        .flush     (flush),
        .out_valid (out_valid),
        .c         (c)
    );

    typedef struct {
        u64 res;
        int cyc;
        int id;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input u64 got, input u64 exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every out_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out_valid", u64'(out_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("result", c, e.res);
                check("out_valid_cycle", u64'(cyc), u64'(e.cyc));
                $display("txn %0d: c=0x%h at cycle %0d (expected 0x%h at %0d)",
                         e.id, c, cyc, e.res, e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            check("in_ready_timeout", u64'(in_ready), 64'd1);
        end
    endtask

    // Drive one request and record its expected result and output cycle.
    // out_valid is due lat cycles after the accepting edge, i.e. the counter
    // read at that negedge equals the current count + lat.
    task automatic issue(input mdufunc_t f, input u64 xa, input u64 xb,
                         input u64 exp, input int lat);
        exp_t e;
        wait_ready();
        if (in_ready !== 1'b1) return;
        in_valid = 1'b1;
        mdufunc  = f;
        a        = xa;
        b        = xb;
        e.res    = exp;
        e.cyc    = cyc + lat;
        e.id     = n_txn;
        n_txn++;
        sb_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", u64'(sb_q.size()), 64'd0);
        end
    endtask

    initial begin
        u64 ra;
        u64 rb;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_in_ready", u64'(in_ready), 64'd1);
        check("reset_out_valid", u64'(out_valid), 64'd0);
        check("reset_c", c, 64'd0);
        reset = 1'b0;

        // Directed operations
        issue(MDU_MUL,  64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, MUL_LAT);
        issue(MDU_DIV,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
        issue(MDU_REM,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
        issue(MDU_DIV,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT);
        issue(MDU_REM,  64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, DIV_LAT);
        issue(MDU_DIVU, 64'd42, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPC_LAT);
        issue(MDU_REMU, 64'd42, 64'd0, 64'd42, SPC_LAT);
        issue(MDU_DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, SPC_LAT);
        issue(MDU_REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, SPC_LAT);
        issue(MDU_DIVW, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, DIV_LAT);
        issue(MDU_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, MUL_LAT);
        issue(MDU_REMW, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, DIV_LAT);
        issue(MDU_DIVUW, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPC_LAT);

        // Random unsigned ops against language-level reference arithmetic
        for (int i = 0; i < 3; i++) begin
            ra = {$urandom, $urandom};
            rb = u64'($urandom_range(1, 1000000));
            issue(MDU_DIVU, ra, rb, ra / rb, DIV_LAT);
            issue(MDU_REMU, ra, rb, ra % rb, DIV_LAT);
            rb = {$urandom, $urandom};
            issue(MDU_MUL, ra, rb, ra * rb, MUL_LAT);
        end
        wait_drain();

        // Flush mid-divide: no result, idle next cycle, then normal service
        wait_ready();
        in_valid = 1'b1;
        mdufunc  = MDU_DIV;
        a        = 64'd100;
        b        = 64'd3;
        @(negedge clk);
        in_valid = 1'b0;
        check("div_accepted_busy", u64'(in_ready), 64'd0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", u64'(in_ready), 64'd1);
        check("flush_out_valid", u64'(out_valid), 64'd0);
        repeat (70) @(negedge clk);
        issue(MDU_MUL, 64'd6, 64'd7, 64'd42, MUL_LAT);
        wait_drain();

        // Reset in the middle of a busy divide
        wait_ready();
        in_valid = 1'b1;
        mdufunc  = MDU_DIVU;
        a        = 64'd1000;
        b        = 64'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midbusy_reset_in_ready", u64'(in_ready), 64'd1);
        check("midbusy_reset_out_valid", u64'(out_valid), 64'd0);
        check("midbusy_reset_c", c, 64'd0);
        reset = 1'b0;

        // Flush with a simultaneous request in IDLE: nothing accepted
        @(negedge clk);
        in_valid = 1'b1;
        flush    = 1'b1;
        mdufunc  = MDU_DIVU;
        a        = 64'd42;
        b        = 64'd0;
        @(negedge clk);
        in_valid = 1'b0;
        flush    = 1'b0;
        check("flush_blocks_accept", u64'(in_ready), 64'd1);
        repeat (3) @(negedge clk);

        // Service still works afterwards
        issue(MDU_DIVU, 64'd100, 64'd7, 64'd14, DIV_LAT);
        issue(MDU_REMU, 64'd100, 64'd7, 64'd2, DIV_LAT);
        wait_drain();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit for the RV64M integer instructions, sitting in the execute stage beside the single-cycle ALU. It accepts one operation at a time through a ready/valid handshake and returns a 64-bit result after a fixed, operation-dependent latency. The pipeline stalls execute while an operation is outstanding. It is flushed on redirect.

## Interface
- No parameters; data width is fixed at 64 bits (`u64`).
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in 1: operation offered this cycle.
- `in_ready` out 1: unit idle; the operation is accepted on the edge where `in_valid & in_ready`.
- `a`, `b` in 64: operands (rs1, rs2), sampled at accept.
- `mdufunc` in `mdufunc_t`: one of MUL, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW.
- `flush` in 1: abort any operation in flight.
- `out_valid` out 1: one-cycle pulse; `c` is valid.
- `c` out 64: result, held stable until the next accept.

## Operation
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - `in_ready`=1.
  - On accept, latch the operands and function.
  - Go to DONE directly for a special case (below) or, with the macro set, for MUL/MULW.
  - Otherwise load the 6-bit counter with 63 and go to BUSY.
- **BUSY:**
  - One iteration per cycle; the counter decrements.
  - When counter==0, the final iteration completes and the state goes to DONE.
- **DONE:** `out_valid`=1, `c` driven from the result register; always returns to IDLE next cycle.
- **Word ops:**
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Computation is 64-bit.
  - The result is the low 32 bits sign-extended to 64.
- **Multiply:**
  - Low 64 bits of the product only; signed and unsigned give identical low bits, so no sign correction.
  - Shift-add: each iteration adds the multiplicand if multiplier bit0 is set, then shifts the multiplicand left and the multiplier right.
- **Divide:**
  - Restoring, on magnitudes for signed ops: 128-bit {remainder, quotient} shift register.
  - Each iteration shifts left 1, trial-subtracts the divisor from the upper half, and on non-negative keeps the difference and sets quotient bit0.
  - Sign fix after the final iteration:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the dividend's sign.
- **Special cases** (detected at accept, go straight to DONE):
  - Divisor==0: quotient = all ones; remainder = dividend.
  - Signed overflow: 0x8000_0000_0000_0000 / -1 gives quotient = dividend and remainder = 0.
  - The word versions of both fall out of the 64-bit rule after truncation plus sign extension.
- **Flush:**
  - Any state goes to IDLE on the next edge; `out_valid` is 0 next cycle.
  - Flush overrides a simultaneous `in_valid`, so nothing is accepted that cycle.
  - Flush in DONE still lets that cycle's `out_valid` pulse appear; the consumer ignores it.
- **Reset:** state IDLE, `c`=0, `out_valid`=0, `in_ready`=1, counter=0. Reset overrides flush and accept.

## Timing
- Accept at edge E0.
- Iterative op: BUSY during the 64 cycles after E0; `out_valid` in the 65th cycle after E0.
- Special case / fast MUL: `out_valid` in the cycle directly after E0.
- `in_ready` is 0 from E0 until the cycle after DONE.
- Back-to-back throughput: one op per latency+2 cycles.
- `c` is registered; `out_valid` is registered.

## Configuration
- `MDU_FAST_MUL_EN` defined:
  - MUL/MULW computed in one step with the `*` operator and registered.
  - Latency is 1 (accept → DONE).
- Not defined: MUL/MULW use the 64-iteration shift-add path.
- Divide timing is unchanged either way.

## Structure
- In `pipes`: `mdufunc_t` enum and an `mdu_state_t` enum.
- In `common`: existing `u64`, `u32`.
- One sub-module, `divider`:
  - Holds the 128-bit shift register and a per-iteration step.
  - Signals: start, done, quotient, remainder.
- The multiply datapath and the control FSM live in `mdu`.

## Test plan
- MUL a=3, b=-5 → `c`=0xFFFF_FFFF_FFFF_FFF1; `out_valid` 65 cycles after accept (1 with `MDU_FAST_MUL_EN`).
- DIV a=-7, b=2 → 0xFFFF_FFFF_FFFF_FFFD; REM same operands → 0xFFFF_FFFF_FFFF_FFFF; latency 65.
- DIVU a=42, b=0 → 0xFFFF_FFFF_FFFF_FFFF and REMU → 42, each with `out_valid` 1 cycle after accept; DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000, REM → 0.
- DIVW a=0x0000_0001_8000_0000, b=0xFFFF_FFFF → 0xFFFF_FFFF_8000_0000; MULW a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE.
- DIV accepted, `flush` asserted 10 cycles later → no `out_valid` ever; `in_ready`=1 the next cycle; a new MUL 6×7 then returns 42.
- `reset` asserted mid-BUSY → next cycle `in_ready`=1, `out_valid`=0, `c`=0; `flush` together with `in_valid` in IDLE → no accept.
